// File: rtl/lockpick_session_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lockpick_session_arbiter
// Brief    : Round-robin session arbiter sharing one lockpick game core
//            between byte-serial players, with load/stream sequencing and
//            a per-session stall watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module lockpick_session_arbiter #(
    parameter int NUM_PLAYERS = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_PLAYERS-1:0]   req,
    input  logic [NUM_PLAYERS-1:0]   p_valid,
    input  logic [8*NUM_PLAYERS-1:0] p_data,
    output logic [NUM_PLAYERS-1:0]   grant,
    output logic [NUM_PLAYERS-1:0]   pl_ready,
    output logic [NUM_PLAYERS-1:0]   rsp_valid,
    output logic [7:0]               rsp_data,
    output logic [1:0]               rsp_status,
    output logic [NUM_PLAYERS-1:0]   session_done,
    output logic                     abort,
    output logic                     core_n_rst,
    output logic                     core_start,
    output logic                     core_input_enable,
    output logic [7:0]               core_input_data,
    input  logic                     core_output_valid,
    input  logic [7:0]               core_output_data,
    input  logic [1:0]               core_status
);

    localparam int PW = $clog2(NUM_PLAYERS);
    localparam logic [5:0] c_LAST_BYTE   = 6'd63;
    localparam logic [4:0] c_LAST_OUT    = 5'd31;
    localparam logic [9:0] c_WDOG_LIMIT  = 10'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GRANT    = 3'd1,
        S_LOAD     = 3'd2,
        S_WAIT_OUT = 3'd3,
        S_STREAM   = 3'd4,
        S_ABORT    = 3'd5
    } state_t;

    state_t                   r_state, w_state_n;
    logic [NUM_PLAYERS-1:0]   r_grant, w_grant_n;
    logic [PW-1:0]            r_gidx, w_gidx_n;
    logic [PW-1:0]            r_rr_ptr, w_rr_n;
    logic [5:0]               r_byte_cnt, w_byte_n;
    logic [4:0]               r_out_cnt, w_out_n;
    logic [9:0]               r_wdog, w_wdog_n;
    logic                     r_abort_cnt, w_acnt_n;
    logic [1:0]               r_rsp_status, w_status_n;
    logic                     r_core_start, w_start_n;
    logic [NUM_PLAYERS-1:0]   r_done, w_done_n;
    logic                     r_abort, w_kill;
    logic                     r_core_n_rst;
    logic                     r_ie;
    logic [7:0]               r_idata;
    logic [NUM_PLAYERS-1:0]   r_rsp_valid;
    logic [7:0]               r_rsp_data;
    logic                     w_fwd;

    logic [PW-1:0]            w_pick;
    logic [PW:0]              w_sum;
    logic [PW-1:0]            w_rr_inc;
    logic                     w_g_req;
    logic                     w_g_valid;
    logic [7:0]               w_g_data;
    logic                     w_xfer;
    logic                     w_wdog_exp;

    // Grantee index is only meaningful outside IDLE, where every use is gated.
    assign w_g_req    = req[r_gidx];
    assign w_g_valid  = p_valid[r_gidx];
    assign w_g_data   = p_data[{r_gidx, 3'b000} +: 8];
    assign w_xfer     = (r_state == S_LOAD) && w_g_valid;
    assign w_wdog_exp = (r_wdog == c_WDOG_LIMIT);
    assign w_rr_inc   = (r_gidx == PW'(NUM_PLAYERS - 1)) ? '0 : r_gidx + 1'b1;

    // Descending scan so the smallest offset from rr_ptr wins.
    always_comb begin
        w_pick = '0;
        w_sum  = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_rr_ptr} + (PW+1)'(i);
            if (w_sum >= (PW+1)'(NUM_PLAYERS))
                w_sum = w_sum - (PW+1)'(NUM_PLAYERS);
            if (req[w_sum[PW-1:0]])
                w_pick = w_sum[PW-1:0];
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_grant_n  = r_grant;
        w_gidx_n   = r_gidx;
        w_rr_n     = r_rr_ptr;
        w_byte_n   = r_byte_cnt;
        w_out_n    = r_out_cnt;
        w_status_n = r_rsp_status;
        w_wdog_n   = '0;
        w_acnt_n   = 1'b0;
        w_start_n  = 1'b0;
        w_done_n   = '0;
        w_kill     = 1'b0;
        w_fwd      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_n = S_GRANT;
                    w_grant_n = {{(NUM_PLAYERS-1){1'b0}}, 1'b1} << w_pick;
                    w_gidx_n  = w_pick;
                    w_start_n = 1'b1;
                end
            end
            S_GRANT: begin
                if (!w_g_req) begin
                    w_kill = 1'b1;
                end else begin
                    w_state_n = S_LOAD;
                    w_byte_n  = '0;
                end
            end
            S_LOAD: begin
                // A transfer beats a coincident watchdog expiry.
                if (!w_g_req) begin
                    w_kill = 1'b1;
                end else if (w_xfer) begin
                    w_byte_n = r_byte_cnt + 6'd1;
                    if (r_byte_cnt == c_LAST_BYTE)
                        w_state_n = S_WAIT_OUT;
                end else if (w_wdog_exp) begin
                    w_kill = 1'b1;
                end else begin
                    w_wdog_n = r_wdog + 10'd1;
                end
            end
            S_WAIT_OUT: begin
                // Core status is only valid alongside its byte stream.
                if (!w_g_req) begin
                    w_kill = 1'b1;
                end else if (core_output_valid) begin
                    w_status_n = core_status;
                    w_out_n    = 5'd1;
                    w_state_n  = S_STREAM;
                    w_fwd      = 1'b1;
                end else if (w_wdog_exp) begin
                    w_kill = 1'b1;
                end else begin
                    w_wdog_n = r_wdog + 10'd1;
                end
            end
            S_STREAM: begin
                if (core_output_valid && r_out_cnt == c_LAST_OUT) begin
                    if (r_rsp_status[1]) begin
                        w_state_n = S_IDLE;
                        w_grant_n = '0;
                        w_rr_n    = w_rr_inc;
                        w_done_n  = r_grant;
                        w_fwd     = 1'b1;
                    end else if (r_rsp_status == 2'b01 && w_g_req) begin
                        w_state_n = S_LOAD;
                        w_byte_n  = '0;
                        w_fwd     = 1'b1;
                    end else begin
                        w_kill = 1'b1;
                    end
                end else if (!w_g_req) begin
                    w_kill = 1'b1;
                end else if (core_output_valid) begin
                    w_out_n = r_out_cnt + 5'd1;
                    w_fwd   = 1'b1;
                end else if (w_wdog_exp) begin
                    w_kill = 1'b1;
                end else begin
                    w_wdog_n = r_wdog + 10'd1;
                end
            end
            S_ABORT: begin
                w_acnt_n = 1'b1;
                if (r_abort_cnt) begin
                    w_state_n = S_IDLE;
                    w_acnt_n  = 1'b0;
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        if (w_kill) begin
            w_state_n = S_ABORT;
            w_grant_n = '0;
            w_rr_n    = w_rr_inc;
        end

        if (w_state_n == S_IDLE && r_state != S_IDLE)
            w_status_n = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_gidx       <= '0;
            r_rr_ptr     <= '0;
            r_byte_cnt   <= '0;
            r_out_cnt    <= '0;
            r_wdog       <= '0;
            r_abort_cnt  <= 1'b0;
            r_rsp_status <= '0;
            r_core_start <= 1'b0;
            r_done       <= '0;
            r_abort      <= 1'b0;
            r_core_n_rst <= 1'b0;
            r_ie         <= 1'b0;
            r_idata      <= '0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
        end else begin
            r_state      <= w_state_n;
            r_grant      <= w_grant_n;
            r_gidx       <= w_gidx_n;
            r_rr_ptr     <= w_rr_n;
            r_byte_cnt   <= w_byte_n;
            r_out_cnt    <= w_out_n;
            r_wdog       <= w_wdog_n;
            r_abort_cnt  <= w_acnt_n;
            r_rsp_status <= w_status_n;
            r_core_start <= w_start_n;
            r_done       <= w_done_n;
            r_abort      <= w_kill;
            r_core_n_rst <= (w_state_n != S_ABORT);
            r_ie         <= w_xfer;
            r_idata      <= w_xfer ? w_g_data : 8'h00;
            r_rsp_valid  <= w_fwd ? r_grant : '0;
            r_rsp_data   <= w_fwd ? core_output_data : 8'h00;
        end
    end

    assign grant             = r_grant;
    assign pl_ready          = (r_state == S_LOAD) ? r_grant : '0;
    assign rsp_valid         = r_rsp_valid;
    assign rsp_data          = r_rsp_data;
    assign rsp_status        = r_rsp_status;
    assign session_done      = r_done;
    assign abort             = r_abort;
    assign core_n_rst        = r_core_n_rst;
    assign core_start        = r_core_start;
    assign core_input_enable = r_ie;
    assign core_input_data   = r_idata;

endmodule
`default_nettype wire

// File: tb/tb_lockpick_session_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lockpick_session_arbiter
// Brief    : Directed self-checking bench for lockpick_session_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lockpick_session_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   p_valid = '0;
    logic [8*N-1:0] p_data = '0;
    logic [N-1:0]   grant, pl_ready, rsp_valid, session_done;
    logic [7:0]     rsp_data, core_input_data;
    logic [1:0]     rsp_status;
    logic           abort, core_n_rst, core_start, core_input_enable;
    logic           core_output_valid = 1'b0;
    logic [7:0]     core_output_data = 8'h00;
    logic [1:0]     core_status = 2'b00;

    lockpick_session_arbiter #(.NUM_PLAYERS(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .p_valid(p_valid), .p_data(p_data),
        .grant(grant), .pl_ready(pl_ready), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_status(rsp_status),
        .session_done(session_done), .abort(abort), .core_n_rst(core_n_rst),
        .core_start(core_start), .core_input_enable(core_input_enable),
        .core_input_data(core_input_data), .core_output_valid(core_output_valid),
        .core_output_data(core_output_data), .core_status(core_status)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Event counters observed on the falling edge.
    int         n_start = 0, n_ie = 0, ie_bad = 0, lat_bad = 0, rsp_bad = 0, n_abort = 0;
    int         n_rsp [N] = '{default: 0};
    int         n_done[N] = '{default: 0};
    logic [1:0] stat_q[$];
    logic       prev_xfer = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    logic [N-1:0] prev_rsp = '0;

    always @(negedge clk) begin
        if (core_start) n_start++;
        if (core_input_enable !== prev_xfer) lat_bad++;
        if (core_input_enable) begin
            n_ie++;
            if (core_input_data !== prev_byte) ie_bad++;
        end
        if (abort) n_abort++;
        for (int i = 0; i < N; i++) begin
            if (rsp_valid[2'(i)]) n_rsp[i]++;
            if (session_done[2'(i)]) n_done[i]++;
        end
        if (rsp_valid != '0 && rsp_data !== 8'hCE) rsp_bad++;
        if (rsp_valid != '0 && prev_rsp == '0) stat_q.push_back(rsp_status);
        prev_rsp  = rsp_valid;
        prev_xfer = 1'b0;
        prev_byte = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (p_valid[2'(i)] && pl_ready[2'(i)]) begin
                prev_xfer = 1'b1;
                prev_byte = p_data[8*i +: 8];
            end
        end
    end

    task automatic send_bytes(input logic [1:0] p, input int n);
        int b = 0;
        int guard = 0;
        while (b < n && guard < 2000) begin
            p_valid[p] = 1'b1;
            p_data[8*p +: 8] = 8'(b);
            @(negedge clk);
            if (pl_ready[p]) b++;
            @(posedge clk);
            #1;
            guard++;
        end
        p_valid[p] = 1'b0;
        total++;
        if (b !== n) begin
            bad++;
            $display("FAIL send_p%0d: accepted %0d bytes, required %0d", p, b, n);
        end
    endtask

    task automatic core_stream(input logic [1:0] st, input int ie_target, input bit drop_last);
        int guard = 0;
        while (n_ie < ie_target && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (n_ie < ie_target) begin
            bad++;
            $display("FAIL stream_wait: input enables %0d, required %0d", n_ie, ie_target);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            core_output_valid = 1'b1;
            core_output_data  = 8'hCE;
            core_status       = st;
            if (drop_last && i == 31) req = '0;
            @(posedge clk);
            #1;
        end
        core_output_valid = 1'b0;
        core_output_data  = 8'h00;
        core_status       = 2'b00;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({grant, pl_ready, rsp_valid, rsp_data, rsp_status, session_done, abort,
             core_n_rst, core_start, core_input_enable, core_input_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: grant=%b rsp_valid=%b n_rst=%b start=%b ie=%b, required all 0",
                     grant, rsp_valid, core_n_rst, core_start, core_input_enable);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (core_n_rst !== 1'b0) begin
            bad++;
            $display("FAIL reset_nrst_hold: core_n_rst=%b, required 0", core_n_rst);
        end
        @(negedge clk);
        total++;
        if (core_n_rst !== 1'b1) begin
            bad++;
            $display("FAIL reset_nrst_release: core_n_rst=%b, required 1", core_n_rst);
        end
        total++;
        if (grant !== '0) begin
            bad++;
            $display("FAIL reset_grant: grant=%b, required 0000", grant);
        end
    endtask

    task automatic test_round_robin();
        int d0 [N];
        int ab0;
        int c;
        logic [N-1:0] exp_g;
        for (int i = 0; i < N; i++) d0[i] = n_done[i];
        ab0 = n_abort;
        req = '1;
        for (int s = 0; s < 5; s++) begin
            int t;
            exp_g = 4'b0001 << (s % 4);
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (grant == '0 && c < 20);
            total++;
            if (grant !== exp_g) begin
                bad++;
                $display("FAIL rr_grant_%0d: grant=%b, required %b", s, grant, exp_g);
            end
            t = n_ie + 64;
            fork
                send_bytes(2'(s % 4), 64);
                core_stream(2'b10, t, s == 4);
            join
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            total++;
            if (n_done[i] - d0[i] !== ((i == 0) ? 2 : 1)) begin
                bad++;
                $display("FAIL rr_done_p%0d: pulses=%0d, required %0d", i, n_done[i] - d0[i],
                         (i == 0) ? 2 : 1);
            end
        end
        total++;
        if (n_abort - ab0 !== 0) begin
            bad++;
            $display("FAIL rr_drop_vs_done: abort pulses=%0d, required 0", n_abort - ab0);
        end
    endtask

    task automatic test_single_win();
        int st0 = n_start, ie0 = n_ie, ieb0 = ie_bad, lat0 = lat_bad, rb0 = rsp_bad;
        int r0 = n_rsp[2], d0 = n_done[2], q0 = stat_q.size();
        int c = 0;
        req = 4'b0100;
        do begin
            @(negedge clk);
            c++;
        end while (grant == '0 && c < 10);
        total++;
        if (c !== 1 || grant !== 4'b0100) begin
            bad++;
            $display("FAIL win_grant: grant=%b after %0d cycles, required 0100 after 1", grant, c);
        end
        total++;
        if (core_start !== 1'b1) begin
            bad++;
            $display("FAIL win_start: core_start=%b in GRANT, required 1", core_start);
        end
        fork
            send_bytes(2'd2, 64);
            core_stream(2'b10, ie0 + 64, 1'b0);
        join
        req = '0;
        repeat (3) @(negedge clk);
        total++;
        if (n_start - st0 !== 1) begin
            bad++;
            $display("FAIL win_start_cnt: pulses=%0d, required 1", n_start - st0);
        end
        total++;
        if (n_ie - ie0 !== 64 || ie_bad !== ieb0 || lat_bad !== lat0) begin
            bad++;
            $display("FAIL win_load: enables=%0d data_err=%0d lat_err=%0d, required 64/0/0",
                     n_ie - ie0, ie_bad - ieb0, lat_bad - lat0);
        end
        total++;
        if (n_rsp[2] - r0 !== 32 || rsp_bad !== rb0) begin
            bad++;
            $display("FAIL win_stream: rsp_valid[2]=%0d data_err=%0d, required 32/0",
                     n_rsp[2] - r0, rsp_bad - rb0);
        end
        total++;
        if (stat_q.size() != q0 + 1 || stat_q[q0] !== 2'b10) begin
            bad++;
            $display("FAIL win_status: streams=%0d, required 1 with status 10", stat_q.size() - q0);
        end
        total++;
        if (n_done[2] - d0 !== 1 || grant !== '0) begin
            bad++;
            $display("FAIL win_done: done=%0d grant=%b, required 1/0000", n_done[2] - d0, grant);
        end
        total++;
        if (rsp_status !== 2'b00) begin
            bad++;
            $display("FAIL win_status_clear: rsp_status=%b in IDLE, required 00", rsp_status);
        end
    endtask

    task automatic test_lockout();
        int st0 = n_start, ie0 = n_ie, ieb0 = ie_bad, r0 = n_rsp[1], d0 = n_done[1];
        int ab0 = n_abort, q0 = stat_q.size();
        int c = 0;
        logic [1:0] exp_st [3] = '{2'b01, 2'b01, 2'b11};
        req = 4'b0010;
        do begin
            @(negedge clk);
            c++;
        end while (grant == '0 && c < 10);
        total++;
        if (grant !== 4'b0010) begin
            bad++;
            $display("FAIL lock_grant: grant=%b, required 0010", grant);
        end
        fork
            begin
                send_bytes(2'd1, 64);
                send_bytes(2'd1, 64);
                send_bytes(2'd1, 64);
            end
            begin
                core_stream(2'b01, ie0 + 64, 1'b0);
                core_stream(2'b01, ie0 + 128, 1'b0);
                core_stream(2'b11, ie0 + 192, 1'b0);
            end
        join
        req = '0;
        repeat (3) @(negedge clk);
        total++;
        if (n_start - st0 !== 1 || n_ie - ie0 !== 192 || ie_bad !== ieb0) begin
            bad++;
            $display("FAIL lock_loads: starts=%0d enables=%0d data_err=%0d, required 1/192/0",
                     n_start - st0, n_ie - ie0, ie_bad - ieb0);
        end
        total++;
        if (n_rsp[1] - r0 !== 96) begin
            bad++;
            $display("FAIL lock_streams: rsp_valid[1]=%0d, required 96", n_rsp[1] - r0);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (stat_q.size() <= q0 + k) begin
                bad++;
                $display("FAIL lock_status_%0d: stream missing, required status %b", k, exp_st[k]);
            end else if (stat_q[q0 + k] !== exp_st[k]) begin
                bad++;
                $display("FAIL lock_status_%0d: rsp_status=%b, required %b", k, stat_q[q0 + k], exp_st[k]);
            end
        end
        total++;
        if (n_done[1] - d0 !== 1 || n_abort - ab0 !== 0) begin
            bad++;
            $display("FAIL lock_done: done=%0d aborts=%0d, required 1/0", n_done[1] - d0, n_abort - ab0);
        end
    endtask

    task automatic test_watchdog();
        int c = 0;
        int d0 = n_done[3];
        req = 4'b1001;
        do begin
            @(negedge clk);
            c++;
        end while (grant == '0 && c < 10);
        total++;
        if (grant !== 4'b1000) begin
            bad++;
            $display("FAIL wd_grant: grant=%b, required 1000", grant);
        end
        send_bytes(2'd3, 10);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!abort && c < 40);
        total++;
        if (c !== 17) begin
            bad++;
            $display("FAIL wd_latency: abort seen %0d edges after last transfer, required 16", c - 1);
        end
        total++;
        if (core_n_rst !== 1'b0 || grant !== '0) begin
            bad++;
            $display("FAIL wd_abort1: core_n_rst=%b grant=%b, required 0/0000", core_n_rst, grant);
        end
        @(negedge clk);
        total++;
        if (core_n_rst !== 1'b0 || abort !== 1'b0) begin
            bad++;
            $display("FAIL wd_abort2: core_n_rst=%b abort=%b, required 0/0", core_n_rst, abort);
        end
        @(negedge clk);
        total++;
        if (core_n_rst !== 1'b1) begin
            bad++;
            $display("FAIL wd_nrst_len: core_n_rst=%b after 2 cycles, required 1", core_n_rst);
        end
        c = 0;
        while (grant == '0 && c < 10) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (grant !== 4'b0001 || n_done[3] - d0 !== 0) begin
            bad++;
            $display("FAIL wd_next: grant=%b done=%0d, required 0001/0", grant, n_done[3] - d0);
        end
        req = '0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_req_drop();
        int d0 = n_done[1];
        int r0 = n_rsp[1];
        int ie0 = n_ie;
        int c = 0;
        int late = 0;
        req = 4'b0010;
        do begin
            @(negedge clk);
            c++;
        end while (grant == '0 && c < 10);
        total++;
        if (grant !== 4'b0010) begin
            bad++;
            $display("FAIL drop_grant: grant=%b, required 0010", grant);
        end
        fork
            send_bytes(2'd1, 64);
            begin
                int g = 0;
                while (n_ie < ie0 + 64 && g < 500) begin
                    @(negedge clk);
                    g++;
                end
                @(posedge clk);
                #1;
                for (int i = 0; i < 32; i++) begin
                    core_output_valid = 1'b1;
                    core_output_data  = 8'hCE;
                    core_status       = 2'b10;
                    if (i == 5) req = '0;
                    @(negedge clk);
                    if (i == 5) begin
                        total++;
                        if (abort !== 1'b0) begin
                            bad++;
                            $display("FAIL drop_early: abort=%b before drop sampled, required 0", abort);
                        end
                    end
                    if (i == 6) begin
                        total++;
                        if (abort !== 1'b1 || grant !== '0 || core_n_rst !== 1'b0) begin
                            bad++;
                            $display("FAIL drop_abort: abort=%b grant=%b n_rst=%b, required 1/0000/0",
                                     abort, grant, core_n_rst);
                        end
                    end
                    if (i >= 6 && rsp_valid !== '0) late++;
                    @(posedge clk);
                    #1;
                end
                core_output_valid = 1'b0;
                core_output_data  = 8'h00;
                core_status       = 2'b00;
            end
        join
        repeat (3) @(negedge clk);
        total++;
        if (late !== 0 || n_rsp[1] - r0 < 5 || n_rsp[1] - r0 > 6) begin
            bad++;
            $display("FAIL drop_rsp: bytes after abort=%0d forwarded=%0d, required 0 and 5..6",
                     late, n_rsp[1] - r0);
        end
        total++;
        if (n_done[1] - d0 !== 0) begin
            bad++;
            $display("FAIL drop_done: session_done pulses=%0d, required 0", n_done[1] - d0);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_win();
        test_lockout();
        test_watchdog();
        test_req_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/lockpick_session_arbiter.md
# lockpick_session_arbiter

Shares one `tt_um_mmorri22_lockpick_game` core between up to `NUM_PLAYERS` byte-serial players. It grants the core round-robin and sequences each session: start pulse, 64-byte key load, 32-byte result stream back to the grantee, and repeated loads after error results. It ends a session on win or lockout. A per-session watchdog aborts stalled sessions by resetting the core. Sits between the player-facing pads/mux and the core.

## Interface
- `NUM_PLAYERS`, 4, number of requesters (2..8); `PW = $clog2(NUM_PLAYERS)`.
- `TIMEOUT`, 255, max consecutive idle cycles in LOAD or WAIT_OUT before abort (1..1023).

- `clk` in 1, single clock.
- `rst` in 1, asynchronous, active-high reset.
- `req` in NUM_PLAYERS, session request, level, per player.
- `p_valid` in NUM_PLAYERS, player byte valid.
- `p_data` in 8*NUM_PLAYERS, player bytes, player i at [8i+:8].
- `grant` out NUM_PLAYERS, one-hot owner of the core, 0 when free.
- `pl_ready` out NUM_PLAYERS, byte accept, only the granted bit in LOAD.
- `rsp_valid` out NUM_PLAYERS, result byte strobe to the grantee.
- `rsp_data` out 8, result byte, broadcast.
- `rsp_status` out 2, latched core status of the current stream.
- `session_done` out NUM_PLAYERS, 1-cycle pulse at session end (win/lockout).
- `abort` out 1, 1-cycle pulse when the watchdog or a request drop kills a session.
- `core_n_rst` out 1, core reset, active-low.
- `core_start`, `core_input_enable` out 1; `core_input_data` out 8.
- `core_output_valid` in 1; `core_output_data` in 8; `core_status` in 2.

## Operation
- States: IDLE, GRANT, LOAD, WAIT_OUT, STREAM, ABORT.
- IDLE: if any `req`, pick the first requester at or after `rr_ptr` (wrapping). Set `grant` and go to GRANT. `rr_ptr` is 0 after reset.
- GRANT, 1 cycle: `core_start`=1. Go to LOAD with `byte_cnt`=0.
- LOAD:
  - `pl_ready[g]`=1, combinational.
  - A transfer occurs when `p_valid[g]&pl_ready[g]`. On the next cycle, `core_input_enable`=1 and `core_input_data`=byte.
  - `byte_cnt` (6 bit) increments per transfer. The 64th transfer (cnt 63) goes to WAIT_OUT.
- WAIT_OUT: wait for `core_output_valid`. On the first strobe, latch `core_status` into `rsp_status`, set `out_cnt`=1 and go to STREAM.
- STREAM: count `core_output_valid` strobes. On the 32nd strobe:
  - latched status 01: go to LOAD for the next attempt, `byte_cnt`=0, no new start.
  - latched status 10 or 11: pulse `session_done[g]`, clear `grant`, set `rr_ptr`=g+1 (mod N), go to IDLE.
  - latched status 00 (illegal): treated as abort.
- Every core byte is forwarded to the grantee with 1-cycle latency: `rsp_valid[g]`, `rsp_data`.
- Watchdog: counts cycles without a transfer in LOAD, or without a strobe in WAIT_OUT/STREAM. It reloads on each transfer or strobe. Reaching TIMEOUT goes to ABORT.
- Request drop: `req[g]` low in any state except IDLE/ABORT goes to ABORT the next cycle.
- ABORT, 2 cycles: `core_n_rst`=0, `abort` pulses in the first cycle, `grant` is cleared, `rr_ptr`=g+1. Then IDLE.
- `rsp_status` holds until the next latch. It clears to 00 on IDLE entry.

## Timing
- All outputs are registered except `pl_ready`.
- Reset values:
  - `core_n_rst`=0 while `rst` is high; it goes to 1 on the first clock edge after release.
  - All other outputs are 0.
- `req` seen at edge k: `grant` at k+1, `core_start` during GRANT (cycle k+1..k+2), earliest `pl_ready` at k+2.
- Forward latency is 1 cycle for both directions. Back-to-back transfers sustain 1 byte/cycle.
- The core drops its status to 00 the cycle after its last output byte. The latch on the first strobe is therefore mandatory.
- A simultaneous watchdog expiry and 64th transfer: the transfer wins (go to WAIT_OUT).
- A simultaneous `req` drop and 32nd strobe with status 10/11: `session_done` wins, no abort.
- `rst` mid-session: immediate return to IDLE, `core_n_rst`=0, all strobes 0.

## Test plan
- Reset: assert `rst` for 3 cycles. Required: all outputs 0 and `core_n_rst`=0; `core_n_rst`=1 one cycle after release; `grant`=0.
- Single win:
  - Stimulus: `req`=0100. Player 2 sends bytes 0x00..0x3F back-to-back. Core stub returns 32×0xCE with status 10.
  - Required: `grant`=0100, one `core_start` pulse, 64 `core_input_enable` with data 0x00..0x3F one cycle delayed.
  - Required: 32 `rsp_valid[2]` with 0xCE, `rsp_status`=10, one `session_done[2]` pulse, `grant`=0.
- Lockout: stub returns statuses 01, 01, 11. Required: 3 loads of 64 bytes, only one `core_start`, 3 streams of 32, `rsp_status` sequence 01/01/11, and one `session_done`.
- Round-robin: `req`=1111 held, each session winning. Required: grant order 0001, 0010, 0100, 1000, 0001.
- Watchdog: TIMEOUT=16, the player stalls after 10 bytes. Required: `abort` pulse 16 cycles after the last transfer, `core_n_rst` low for exactly 2 cycles, next requester granted.
- Request drop: `req[g]` falls during STREAM byte 5. Required: ABORT on the next cycle, `rsp_valid` stops, and no `session_done`.
